muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits; legal values 32 or 64.
REQ-002 Parameter HAS_W, default 1, enables the 32-bit word ops (MULW/DIVW/DIVUW/REMW/REMUW); forced to 0 when XLEN=32.
REQ-003 Port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request strobe; sampled only when busy=0.
REQ-006 Port funct3  input  3  RV M-extension op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 Port op32  input  1  word-op select; ignored when HAS_W=0.
REQ-008 Port srcA  input  XLEN  multiplicand or dividend.
REQ-009 Port srcB  input  XLEN  multiplier or divisor.
REQ-010 Port busy  output  1  computation in progress; new starts ignored.
REQ-011 Port done  output  1  one-cycle pulse: result is valid.
REQ-012 Port result  output  XLEN  final value; held stable from done until the next accepted start.

Function
REQ-013 FSM states: IDLE, CALC, DONE; start is accepted in IDLE or DONE, and the accept edge latches funct3, op32, srcA and srcB.
REQ-014 Effective width N = 32 when op32=1, else XLEN; for word ops, operands use bits [31:0] and the 32-bit result is sign-extended to XLEN.
REQ-015 Normal op: accept -> CALC for exactly N cycles (radix-2 shift-add multiply or restoring divide, one bit per cycle) -> DONE for 1 cycle -> IDLE unless start is present.
REQ-016 Latency: done asserts N+1 cycles after the accept edge (65 for XLEN=64, 33 for word ops).
REQ-017 busy=1 exactly while in CALC; busy=0 in IDLE and DONE; done=1 only in DONE.
REQ-018 Signed ops use magnitude iteration with sign fix-up at completion: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned; MUL returns the low N bits, MULH* return the high N bits of the 2N-bit product.
REQ-019 Divide by zero: quotient is all ones (-1), remainder is the dividend; skips CALC, done asserts on the cycle after accept.
REQ-020 Signed overflow (dividend = most negative N-bit value, divisor = -1): quotient is the dividend, remainder is 0; skips CALC, latency 1.
REQ-021 Remainder sign follows the dividend; quotient truncates toward zero.
REQ-022 start while busy=1 is ignored, and the latched operands do not change.
REQ-023 start in DONE: the done pulse and result are still presented that cycle, and the new op is accepted on the same edge.

Reset
REQ-024 reset has priority over start; state -> IDLE and busy, done, result -> 0 on the next edge.
REQ-025 reset during CALC aborts the op without asserting done; start is accepted on the first cycle after reset deasserts.

Structure
REQ-026 M-extension funct3 encodings, the MULDIV opcode/funct7 value (0000001) and the state encodings belong in the shared diagv2_const.vh.
REQ-027 Single module with no sub-modules; one shared 2N-bit accumulator/shift register serves both multiply and divide.

Verification
REQ-028 MUL, XLEN=64, srcA=7, srcB=-3 -> result 0xFFFFFFFFFFFFFFEB; done exactly 65 cycles after the accept edge; busy high for 64 cycles.
REQ-029 MULHU, srcA=0xFFFFFFFFFFFFFFFF, srcB=2 -> result 1; MULH of the same operands -> 0xFFFFFFFFFFFFFFFF.
REQ-030 DIV, srcA=100, srcB=0 -> result 0xFFFFFFFFFFFFFFFF; REM of the same operands -> 100; each with done 1 cycle after accept.
REQ-031 DIV, srcA=0x8000000000000000, srcB=-1 -> result 0x8000000000000000; REM -> 0; latency 1.
REQ-032 DIVW, srcA=-7, srcB=2 -> 0xFFFFFFFFFFFFFFFD; REMW -> 0xFFFFFFFFFFFFFFFF; latency 33.
REQ-033 reset asserted 10 cycles into a DIVU -> busy=0, done=0 with no done pulse; start next cycle, MULW 3*5 -> result 15 after 33 cycles.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the RV M-extension multiply/divide unit.
//   - funct3 encodings of the eight M-extension operations
//   - funct7 value that selects the MULDIV group inside the OP/OP-32 opcodes
//   - FSM state encoding used by muldiv_unit
//   - small decode helpers for operand signedness
package muldiv_unit_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdState_t;

    // First operand is treated as two's complement
    function automatic logic isSignedA(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Second operand is treated as two's complement
    function automatic logic isSignedB(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit.
// One result bit per cycle: radix-2 shift-add multiply or restoring divide on
// operand magnitudes, with the sign applied when the last bit is produced.
// A single 2*XLEN accumulator serves both operations. Divide-by-zero and
// signed overflow are resolved at accept time and skip the iteration.
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   reset   in   synchronous active-high reset
//   start   in   request strobe, accepted only while busy=0
//   funct3  in   M-extension operation (MUL..REMU)
//   op32    in   word-op select (MULW/DIVW/...), ignored without word support
//   srcA    in   multiplicand / dividend
//   srcB    in   multiplier / divisor
//   busy    out  iteration in progress
//   done    out  one-cycle pulse, result valid
//   result  out  final value, held until the next accepted start
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int HAS_W = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            op32,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam bit WORD_EN = (XLEN == 64) && (HAS_W != 0);
    localparam int CNT_W   = $clog2(XLEN);
    // Word divides park the 32-bit dividend at the top of the low half so the
    // same shift path feeds the remainder half as in full-width divides.
    localparam int WSHIFT  = XLEN - 32;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        logic signed [31:0] w;
        w = x[31:0];
        return XLEN'(w);
    endfunction

    function automatic logic [XLEN-1:0] negIf(input logic neg, input logic [XLEN-1:0] x);
        return neg ? -x : x;
    endfunction

    function automatic logic [XLEN-1:0] wordFix(input logic isWord, input logic [XLEN-1:0] x);
        return isWord ? sext32(x) : x;
    endfunction

    mdState_t            state;
    logic [CNT_W-1:0]    cnt;

    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opB;
    logic [2:0]          funct3Q;
    logic                wordQ;
    logic                negAQ;
    logic                negBQ;

    logic                accept;
    logic                wordIn;
    logic                sgnA;
    logic                sgnB;
    logic [XLEN-1:0]     aIn;
    logic [XLEN-1:0]     bIn;
    logic                negA;
    logic                negB;
    logic [XLEN-1:0]     magA;
    logic [XLEN-1:0]     magB;
    logic                divZero;
    logic                divOvf;
    logic [XLEN-1:0]     minVal;
    logic [XLEN-1:0]     specialRes;
    logic [2*XLEN-1:0]   accInit;
    logic [CNT_W-1:0]    cntInit;

    logic [XLEN:0]       mulSum;
    logic [2*XLEN:0]     divSh;
    logic [XLEN:0]       divUp;
    logic [XLEN-1:0]     divDiff;
    logic                divFit;
    logic [2*XLEN-1:0]   accNext;
    logic [2*XLEN-1:0]   prod;
    logic [2*XLEN-1:0]   prodFix;
    logic [XLEN-1:0]     mulRes;
    logic [XLEN-1:0]     divRes;
    logic [XLEN-1:0]     finalRes;

    assign accept = start && (state != S_CALC);

    // Operand decode: extend word operands to XLEN first so that sign tests,
    // magnitudes and special-case compares are width independent.
    always_comb begin
        wordIn = op32 & WORD_EN;
        sgnA   = isSignedA(funct3);
        sgnB   = isSignedB(funct3);
        aIn    = srcA;
        bIn    = srcB;
        if (wordIn) begin
            aIn = sgnA ? sext32(srcA) : XLEN'(srcA[31:0]);
            bIn = sgnB ? sext32(srcB) : XLEN'(srcB[31:0]);
        end
        negA   = sgnA & aIn[XLEN-1];
        negB   = sgnB & bIn[XLEN-1];
        magA   = negIf(negA, aIn);
        magB   = negIf(negB, bIn);

        minVal  = wordIn ? sext32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        divZero = funct3[2] && (bIn == '0);
        divOvf  = funct3[2] && sgnB && (aIn == minVal) && (bIn == '1);

        // funct3[1] selects remainder within the divide group
        if (divZero) specialRes = funct3[1] ? aIn : '1;
        else         specialRes = funct3[1] ? '0  : aIn;
        specialRes = wordFix(wordIn, specialRes);

        accInit = {{XLEN{1'b0}}, magA};
        if (funct3[2] && wordIn) accInit = accInit << WSHIFT;
        cntInit = wordIn ? CNT_W'(31) : CNT_W'(XLEN - 1);
    end

    // One iteration of the shared accumulator, plus sign fix-up of the value
    // it produces on the final step.
    always_comb begin
        mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opB} : '0);
        divSh   = {acc, 1'b0};
        divUp   = divSh[2*XLEN:XLEN];
        divFit  = divUp >= {1'b0, opB};
        divDiff = divUp[XLEN-1:0] - opB;

        if (funct3Q[2]) begin
            if (divFit) accNext = {divDiff, divSh[XLEN-1:1], 1'b1};
            else        accNext = divSh[2*XLEN-1:0];
        end else begin
            accNext = {mulSum, acc[XLEN-1:1]};
        end

        // A word multiply runs only 32 steps, leaving the product 32 bits high
        prod    = wordQ ? (accNext >> WSHIFT) : accNext;
        prodFix = (negAQ ^ negBQ) ? -prod : prod;
        if (funct3Q == F3_MUL) mulRes = prodFix[XLEN-1:0];
        else if (wordQ)        mulRes = XLEN'(prodFix[63:32]);
        else                   mulRes = prodFix[2*XLEN-1:XLEN];

        if (funct3Q[1]) divRes = negIf(negAQ, accNext[2*XLEN-1:XLEN]);
        else            divRes = negIf(negAQ ^ negBQ, accNext[XLEN-1:0]);

        finalRes = wordFix(wordQ, funct3Q[2] ? divRes : mulRes);
    end

    // Control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (divZero || divOvf) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= specialRes;
                        end else begin
                            state <= S_CALC;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            cnt   <= cntInit;
                        end
                    end else begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                S_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= finalRes;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3Q <= funct3;
            wordQ   <= wordIn;
            negAQ   <= negA;
            negBQ   <= negB;
            opB     <= magB;
            acc     <= accInit;
        end else if (state == S_CALC) begin
            acc <= accNext;
        end
    end

endmodule
